// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The master issues operations; the slave returns register-file writes.
interface muldiv_unit_if #(
  parameter int DATA_N = 32
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_N-1:0] rs1_data;
  logic [DATA_N-1:0] rs2_data;
  logic [4:0]        rd_addr_i;
  logic              busy_o;
  logic              rd_wren;
  logic [4:0]        rd_addr;
  logic [DATA_N-1:0] rd_data;

  modport master (
    output start_i,
    output op_i,
    output rs1_data,
    output rs2_data,
    output rd_addr_i,
    input  busy_o,
    input  rd_wren,
    input  rd_addr,
    input  rd_data
  );

  modport slave (
    input  start_i,
    input  op_i,
    input  rs1_data,
    input  rs2_data,
    input  rd_addr_i,
    output busy_o,
    output rd_wren,
    output rd_addr,
    output rd_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle, fixed 33-cycle latency.
// Operates on magnitudes; signs are reapplied when the result is presented.
module muldiv_unit #(
  parameter int DATA_N = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  muldiv_unit_if.slave  bus
);

  localparam int N  = DATA_N;
  localparam int N2 = 2 * DATA_N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [4:0]    r_cnt;
  logic [2:0]    r_op;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_mag_b;
  logic [N2-1:0] r_acc;
  logic          r_neg_a;
  logic          r_neg_b;
  logic [4:0]    r_rd;

  logic          w_accept;
  logic          w_sgn_a;
  logic          w_sgn_b;
  logic          w_neg_a;
  logic          w_neg_b;
  logic [N-1:0]  w_mag_a;
  logic [N-1:0]  w_mag_b;
  logic [N:0]    w_mul_sum;
  logic [N2-1:0] w_mul_nxt;
  logic [N:0]    w_div_trial;
  logic          w_div_ok;
  logic [N2-1:0] w_div_nxt;
  logic [N2-1:0] w_prod;
  logic [N-1:0]  w_quo;
  logic [N-1:0]  w_rem;
  logic [N-1:0]  w_res;

  assign w_accept = (r_state == S_IDLE) && bus.start_i;

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    unique case (bus.op_i)
      3'b001: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      3'b010: begin w_sgn_a = 1'b1; end
      3'b100: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      3'b110: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      default: begin end
    endcase
  end

  assign w_neg_a = w_sgn_a & bus.rs1_data[N-1];
  assign w_neg_b = w_sgn_b & bus.rs2_data[N-1];
  assign w_mag_a = w_neg_a ? -bus.rs1_data : bus.rs1_data;
  assign w_mag_b = w_neg_b ? -bus.rs2_data : bus.rs2_data;

  // Multiplier sits in the low half of r_acc and shifts out as product bits shift in.
  assign w_mul_sum = {1'b0, r_acc[N2-1:N]}
                   + (r_acc[0] ? {1'b0, r_mag_b} : {(N+1){1'b0}});
  assign w_mul_nxt = {w_mul_sum, r_acc[N-1:1]};

  // Restoring divide: remainder in the high half, dividend/quotient in the low half.
  assign w_div_trial = r_acc[N2-1:N-1] - {1'b0, r_mag_b};
  assign w_div_ok    = ~w_div_trial[N];
  assign w_div_nxt   = {
    (w_div_ok ? w_div_trial[N-1:0] : r_acc[N2-2:N-1]),
    r_acc[N-2:0],
    w_div_ok
  };

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start_i) w_next = S_CALC;
      S_CALC: if (r_cnt == 5'd31) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_rd    <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= bus.op_i;
      r_a     <= bus.rs1_data;
      r_b     <= bus.rs2_data;
      r_mag_b <= w_mag_b;
      r_acc   <= {{N{1'b0}}, w_mag_a};
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_rd    <= bus.rd_addr_i;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;

  // A zero divisor bypasses sign fix-up: all-ones quotient, untouched dividend.
  assign w_quo = (r_b == '0) ? {N{1'b1}}
               : ((r_neg_a ^ r_neg_b) ? -r_acc[N-1:0] : r_acc[N-1:0]);
  assign w_rem = (r_b == '0) ? r_a
               : (r_neg_a ? -r_acc[N2-1:N] : r_acc[N2-1:N]);

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      (r_op == 3'b000):          w_res = w_prod[N-1:0];
      (!r_op[2] && r_op != 0):   w_res = w_prod[N2-1:N];
      (r_op[2] && !r_op[1]):     w_res = w_quo;
      (r_op[2] && r_op[1]):      w_res = w_rem;
      default:                   w_res = '0;
    endcase
  end

  always_comb begin
    bus.busy_o  = (r_state != S_IDLE);
    bus.rd_wren = 1'b0;
    bus.rd_addr = '0;
    bus.rd_data = '0;
    if (r_state == S_DONE) begin
      bus.rd_wren = 1'b1;
      bus.rd_addr = r_rd;
      bus.rd_data = w_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors with
// hand-computed results, latency, hold-start and mid-operation reset.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.DATA_N(32)) bus ();

  muldiv_unit #(.DATA_N(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rd_wren) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected none",
                 bus.rd_addr, bus.rd_data);
      end else begin
        m_e = sb.pop_front();
        chk("rd_addr", 32'(bus.rd_addr), 32'(m_e.rd));
        chk("rd_data", bus.rd_data, m_e.d);
        chk("latency", 32'(cyc), 32'(m_e.cyc));
        chk("busy_in_done", 32'(bus.busy_o), 32'd1);
      end
    end
  end

  // Called at a falling edge; start is accepted at the next rising edge.
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                       logic [4:0] rd, logic [31:0] exp, bit push, bit hold);
    exp_t e;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_addr_i = rd;
    @(posedge clk);
    #1;
    if (push) begin
      e.rd  = rd;
      e.d   = exp;
      e.cyc = cyc + 32;
      sb.push_back(e);
    end
    chk("busy_after_accept", 32'(bus.busy_o), 32'd1);
    if (!hold) begin
      @(negedge clk);
      bus.start_i   = 1'b0;
      bus.op_i      = 3'($urandom);
      bus.rs1_data  = $urandom;
      bus.rs2_data  = $urandom;
      bus.rd_addr_i = 5'($urandom);
    end else begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.rd_wren) break;
        bus.op_i      = 3'($urandom);
        bus.rs1_data  = $urandom;
        bus.rs2_data  = $urandom;
        bus.rd_addr_i = 5'($urandom);
      end
      bus.start_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic run(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                     logic [4:0] rd, logic [31:0] exp);
    issue(op, a, b, rd, exp, 1'b1, 1'b0);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i   = 1'b0;
    bus.op_i      = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.rd_addr_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_wren", 32'(bus.rd_wren), 32'd0);
    chk("rst_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_data", bus.rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE);
    run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000);
    run(3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD);
    run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h00000000);
    run(3'b101, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF);
    run(3'b111, 32'd5,        32'd0,        5'd11, 32'd5);
    run(3'b000, 32'd3,        32'd4,        5'd0,  32'd12);
    run(3'b100, 32'd7,        32'd0,        5'd12, 32'hFFFFFFFF);
    run(3'b110, 32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9);
    run(3'b101, 32'd100,      32'd7,        5'd14, 32'd14);
    run(3'b111, 32'd100,      32'd7,        5'd15, 32'd2);
    run(3'b011, 32'h80000000, 32'd4,        5'd16, 32'd2);
    run(3'b001, 32'h80000000, 32'h80000000, 5'd17, 32'h40000000);

    issue(3'b000, 32'h12345678, 32'd16, 5'd20, 32'h23456780, 1'b1, 1'b1);
    wait_idle();

    issue(3'b000, 32'd9, 32'd9, 5'd3, 32'd81, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    chk("calc_busy", 32'(bus.busy_o), 32'd1);
    chk("calc_data_zero", bus.rd_data, 32'd0);
    chk("calc_wren_zero", 32'(bus.rd_wren), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_wren", 32'(bus.rd_wren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", 32'(bus.busy_o), 32'd0);
    run(3'b000, 32'd6, 32'd7, 5'd9, 32'd42);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
